// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
// Owns the PC, requests words from the icache, latches each returned word
// into an instruction register for the control unit, and computes the next
// PC from the control unit's PCsrc/BranchAddr/addr/jr_target/flagZero.
// A HALT instruction parks the unit in a sticky halted state until reset.
//
// Ports
//   CLK, RST     clock, synchronous active-high reset
//   ihit         icache word valid for imemaddr this cycle
//   imemload     icache instruction word
//   imemREN      icache read request (high only while fetching)
//   imemaddr     icache address (= pc)
//   instr        latched instruction -> control unit
//   instr_valid  instr holds the current instruction
//   pc, npc      PC of current instruction, pc + 4
//   PCsrc        0 seq, 2 JR, 3 J/JAL, 4 BNE, 5 BEQ, others seq
//   BranchAddr   sign-extended branch word offset (unshifted)
//   addr         jump target field, [25:0] used
//   jr_target    register target for JR
//   flagZero     ALU zero flag for the current instruction
//   halt         current instruction is HALT
//   advance      current instruction completes this cycle
//   halted       sticky halt indicator
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] npc,
  input  logic [2:0]  PCsrc,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] addr,
  input  logic [31:0] jr_target,
  input  logic        flagZero,
  input  logic        halt,
  input  logic        advance,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [2:0] SRC_JR  = 3'd2;
  localparam logic [2:0] SRC_J   = 3'd3;
  localparam logic [2:0] SRC_BNE = 3'd4;
  localparam logic [2:0] SRC_BEQ = 3'd5;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        ivld_q, ivld_d;
  logic        halted_q, halted_d;

  logic [31:0] npc_w, br_tgt, next_pc;

  // Branch offsets are word offsets; dropping the top two bits before the
  // shift keeps two's complement semantics mod 2^32.
  assign npc_w  = pc_q + 32'd4;
  assign br_tgt = npc_w + {BranchAddr[29:0], 2'b00};

  always_comb begin
    next_pc = npc_w;
    case (PCsrc)
      SRC_JR:  next_pc = jr_target;
      SRC_J:   next_pc = {npc_w[31:28], addr[25:0], 2'b00};
      SRC_BNE: next_pc = flagZero ? npc_w : br_tgt;
      SRC_BEQ: next_pc = flagZero ? br_tgt : npc_w;
      default: next_pc = npc_w;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ivld_d   = ivld_q;
    halted_d = halted_q;
    imemREN  = 1'b0;
    case (state_q)
      FETCH: begin
        imemREN = 1'b1;
        if (ihit) begin
          instr_d = imemload;
          ivld_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // advance=0 is a datapath stall: everything holds.
        if (advance) begin
          ivld_d = 1'b0;
          if (halt) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        ivld_d   = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= FETCH;
      pc_q     <= PC_INIT;
      instr_q  <= 32'h0;
      ivld_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ivld_q   <= ivld_d;
      halted_q <= halted_d;
    end
  end

  assign imemaddr    = pc_q;
  assign pc          = pc_q;
  assign npc         = npc_w;
  assign instr       = instr_q;
  assign instr_valid = ivld_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit. Stimulus pushes the expected
// post-edge view of the unit into a queue; a negedge monitor pops and compares.
module tb_fetch_unit;

  localparam logic [31:0] INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST, ihit, imemREN, instr_valid, flagZero, halt, advance, halted;
  logic [31:0] imemload, imemaddr, instr, pc, npc, BranchAddr, addr, jr_target;
  logic [2:0]  PCsrc;

  fetch_unit #(.PC_INIT(INIT)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .npc(npc), .PCsrc(PCsrc),
    .BranchAddr(BranchAddr), .addr(addr), .jr_target(jr_target),
    .flagZero(flagZero), .halt(halt), .advance(advance), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          rst, ihit, adv, hlt, fz;
    logic [31:0] load, br, ad, jr;
    logic [2:0]  src;
  } stim_t;

  typedef struct {
    logic [31:0] pc, npc, instr;
    bit          ivld, ren, halted;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: "waiting" = looking for an icache word,
  // "busy" = holding an instruction, "dead" = halted.
  logic [31:0] m_pc, m_instr;
  bit          m_ivld, m_halted;
  int          m_mode; // 0 waiting, 1 busy, 2 dead

  function automatic logic [31:0] ref_next(logic [31:0] p, stim_t s);
    logic [31:0] seq, tk;
    seq = p + 4;
    tk  = seq + s.br * 4;
    case (s.src)
      3'd2: return s.jr;
      3'd3: return (seq & 32'hF000_0000) | ((s.ad & 32'h03FF_FFFF) * 4);
      3'd4: return (s.fz == 0) ? tk : seq;
      3'd5: return (s.fz == 1) ? tk : seq;
      default: return seq;
    endcase
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.ihit = 0; s.adv = 0; s.hlt = 0; s.fz = 0;
    s.load = 0; s.br = 0; s.ad = 0; s.jr = 0; s.src = 0;
    return s;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, then advance the model across the same edge.
  task automatic apply(stim_t s);
    exp_t e;
    RST = s.rst; ihit = s.ihit; imemload = s.load; advance = s.adv;
    halt = s.hlt; flagZero = s.fz; BranchAddr = s.br; addr = s.ad;
    jr_target = s.jr; PCsrc = s.src;
    @(posedge CLK); #1;
    if (s.rst) begin
      m_pc = INIT; m_instr = 0; m_ivld = 0; m_halted = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (s.ihit) begin m_instr = s.load; m_ivld = 1; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (s.adv) begin
        m_ivld = 0;
        if (s.hlt) begin m_halted = 1; m_mode = 2; end
        else begin m_pc = ref_next(m_pc, s); m_mode = 0; end
      end
    end
    e.pc = m_pc; e.npc = m_pc + 4; e.instr = m_instr; e.ivld = m_ivld;
    e.ren = (m_mode == 0); e.halted = m_halted;
    q.push_back(e);
  endtask

  // One fetch cycle (ihit) followed by one completing cycle with s.
  task automatic run_instr(stim_t s);
    stim_t f;
    f = idle(); f.ihit = 1; f.load = $urandom;
    apply(f);
    s.adv = 1;
    apply(s);
  endtask

  task automatic set_pc(logic [31:0] v);
    stim_t s;
    s = idle(); s.src = 3'd2; s.jr = v;
    run_instr(s);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("npc", npc, e.npc);
        chk("imemaddr", imemaddr, e.pc);
        chk("instr", instr, e.instr);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, e.ivld});
        chk("imemREN", {31'b0, imemREN}, {31'b0, e.ren});
        chk("halted", {31'b0, halted}, {31'b0, e.halted});
      end
    end
  end

  initial begin : stim
    stim_t s;
    // 1: reset, first fetch, sequential advance
    s = idle(); s.rst = 1; apply(s); apply(s);
    #3 chk("rst_pc", pc, INIT);
    chk("rst_ren", {31'b0, imemREN}, 32'd1);
    s = idle(); s.ihit = 1; s.load = 32'h2001_0005; apply(s);
    #3 chk("first_instr", instr, 32'h2001_0005);
    s = idle(); s.adv = 1; apply(s);
    #3 chk("seq_pc", pc, 32'h4);

    // 2: branches
    set_pc(32'h40);
    s = idle(); s.src = 5; s.fz = 1; s.br = 32'hFFFF_FFFE; run_instr(s);
    #3 chk("beq_taken", pc, 32'h3C);
    set_pc(32'h40);
    s = idle(); s.src = 5; s.fz = 0; s.br = 32'hFFFF_FFFE; run_instr(s);
    #3 chk("beq_not", pc, 32'h44);
    set_pc(32'h40);
    s = idle(); s.src = 4; s.fz = 0; s.br = 32'd3; run_instr(s);
    #3 chk("bne_taken", pc, 32'h50);

    // 3: jumps
    set_pc(32'h1000_0040);
    #3 chk("npc_before", npc, 32'h1000_0044);
    s = idle(); s.src = 3; s.ad = 32'h0000_0100; run_instr(s);
    #3 chk("j_pc", pc, 32'h1000_0400);
    s = idle(); s.src = 2; s.jr = 32'h0000_0ABC; run_instr(s);
    #3 chk("jr_pc", pc, 32'h0000_0ABC);

    // 4: icache miss with advance pulsed, then datapath stall
    for (int i = 0; i < 5; i++) begin s = idle(); s.adv = i[0]; s.src = 2; s.jr = 32'h77; apply(s); end
    s = idle(); s.ihit = 1; s.load = 32'hDEAD_BEEF; apply(s);
    for (int i = 0; i < 4; i++) begin s = idle(); s.ihit = 1; s.load = 32'h1234_5678; apply(s); end
    #3 chk("stall_instr", instr, 32'hDEAD_BEEF);
    s = idle(); s.adv = 1; apply(s);

    // 5: halt is sticky until reset
    s = idle(); s.hlt = 1; s.src = 2; s.jr = 32'h800; run_instr(s);
    for (int i = 0; i < 4; i++) begin s = idle(); s.ihit = 1; s.adv = 1; s.load = $urandom; apply(s); end
    #3 chk("halted_sticky", {31'b0, halted}, 32'd1);
    s = idle(); s.rst = 1; apply(s);

    // 6: wrap and reset mid-stall
    set_pc(32'hFFFF_FFFC);
    s = idle(); run_instr(s);
    #3 chk("wrap_pc", pc, 32'h0);
    s = idle(); s.ihit = 1; s.load = 32'hCAFE_0001; apply(s);
    s = idle(); apply(s); apply(s);
    s = idle(); s.rst = 1; apply(s);
    #3 chk("rst_stall_instr", instr, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst  = ($urandom_range(0, 59) == 0);
      s.ihit = $urandom_range(0, 1);
      s.adv  = ($urandom_range(0, 9) < 6);
      s.hlt  = ($urandom_range(0, 29) == 0);
      s.fz   = $urandom_range(0, 1);
      s.src  = 3'($urandom_range(0, 7));
      s.load = $urandom;
      s.br   = 32'($signed($urandom_range(0, 64)) - 32);
      if ($urandom_range(0, 7) == 0) s.br = $urandom;
      s.ad   = $urandom;
      s.jr   = $urandom;
      apply(s);
    end

    @(negedge CLK); #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
